// File: rtl/wiphase_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wiphase_ram_arb_pkg
// Shared types and constants for the two-master sample/program RAM arbiter.
//   owner_t    : which master currently holds the RAM (or nobody).
//   RAM_DEPTH  : number of valid words in the shared RAM.
//   RAM_ADDR_W : word address width of the RAM.
//   RAM_DATA_W : data width of the RAM.
// -----------------------------------------------------------------------------
package wiphase_ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam int RAM_DEPTH  = 5120;
  localparam int RAM_ADDR_W = 13;
  localparam int RAM_DATA_W = 32;

endpackage

// File: rtl/wiphase_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// wiphase_ram_arbiter_if
// Avalon-MM style master port bundle, one instance per RAM master.
//   address/byteenable/read/write/writedata : master -> arbiter
//   waitrequest/readdata/readdatavalid      : arbiter -> master
// Modports: master (the requester side), slave (the arbiter side).
// -----------------------------------------------------------------------------
interface wiphase_ram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/wiphase_ram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// wiphase_rr_arb2
// Two-way round-robin arbiter with a bounded burst lock.
//   clk, rst       : clock, asynchronous active-high reset
//   req0, req1     : request from master 0 / master 1
//   grant0, grant1 : combinational one-hot (or zero) grant for this cycle
// The current owner keeps the RAM while it requests, until it has had
// MAX_BURST consecutive grants with the other master waiting.
// MAX_BURST legal range is 1..255 (8-bit burst counter).
// -----------------------------------------------------------------------------
module wiphase_rr_arb2
  import wiphase_ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_t     owner_q, owner_d;
  logic [7:0] burst_q, burst_d;
  logic       last_q,  last_d;   // 0 = M0 granted last, 1 = M1 granted last

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt >= MAX_B) ? MAX_B : cnt + 8'd1;
  endfunction

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (owner_q)
      OWN_IDLE: begin
        // Tie from idle goes to whichever master was not served last.
        if (req0 && req1) begin
          if (last_q) grant0 = 1'b1;
          else        grant1 = 1'b1;
        end else if (req0) begin
          grant0 = 1'b1;
        end else if (req1) begin
          grant1 = 1'b1;
        end
      end
      OWN_M0: begin
        if (req0 && ((burst_q < MAX_B) || !req1)) grant0 = 1'b1;
        else if (req1)                             grant1 = 1'b1;
      end
      OWN_M1: begin
        if (req1 && ((burst_q < MAX_B) || !req0)) grant1 = 1'b1;
        else if (req0)                             grant0 = 1'b1;
      end
      default: ;
    endcase
    // No grant may leak out while reset is held.
    if (rst) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    burst_d = 8'd0;
    last_d  = last_q;
    if (grant0) begin
      owner_d = OWN_M0;
      last_d  = 1'b0;
      burst_d = (owner_q == OWN_M0) ? sat_inc(burst_q) : 8'd1;
    end else if (grant1) begin
      owner_d = OWN_M1;
      last_d  = 1'b1;
      burst_d = (owner_q == OWN_M1) ? sat_inc(burst_q) : 8'd1;
    end
  end

  // Reset leaves last = M1 so M0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IDLE;
      burst_q <= 8'd0;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/wiphase_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wiphase_ram_arbiter
// Shares the single-port 5120x32 sample/program RAM between the phase-sample
// capture writer (m0) and the Nios/Avalon host (m1).
//   clk, reset      : clock, asynchronous active-high reset
//   m0, m1          : Avalon-MM master ports (slave modport of the bundle)
//   ram_*           : Avalon slave pins of the RAM; ram_readdata returns one
//                     cycle after the address is presented
//   err_oor         : one-cycle pulse when an out-of-range access is granted
// Out-of-range accesses are granted but never select the RAM; their reads
// return zero. Read data is steered only to the master that issued the read.
// -----------------------------------------------------------------------------
module wiphase_ram_arbiter
  import wiphase_ram_arb_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int BE_W      = DATA_W / 8,
  parameter int DEPTH     = RAM_DEPTH,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  wiphase_ram_arbiter_if.slave  m0,
  wiphase_ram_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [BE_W-1:0]       ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata,
  output logic                  err_oor
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic req0, req1;
  logic grant0, grant1, grant_any;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_rd, sel_wr;
  logic              in_range;

  logic              rd_vld_q, rd_vld_d;
  logic              rd_own_q, rd_own_d;   // 0 = M0 issued the read, 1 = M1
  logic              rd_oor_q, rd_oor_d;
  logic [DATA_W-1:0] rd_data;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  wiphase_rr_arb2 #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk    (clk),
    .rst    (reset),
    .req0   (req0),
    .req1   (req1),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign grant_any      = grant0 | grant1;
  assign m0.waitrequest = ~grant0;
  assign m1.waitrequest = ~grant1;

  always_comb begin
    sel_addr  = grant1 ? m1.address    : m0.address;
    sel_be    = grant1 ? m1.byteenable : m0.byteenable;
    sel_wdata = grant1 ? m1.writedata  : m0.writedata;
    sel_rd    = grant1 ? m1.read       : m0.read;
    sel_wr    = grant1 ? m1.write      : m0.write;
  end

  assign in_range = {1'b0, sel_addr} < DEPTH_L;

  assign ram_address    = sel_addr;
  assign ram_byteenable = sel_be;
  assign ram_writedata  = sel_wdata;
  assign ram_chipselect = grant_any & in_range;
  assign ram_write      = grant_any & sel_wr & in_range;
  assign ram_clken      = 1'b1;
  assign err_oor        = grant_any & ~in_range;

  // A read with write also high is dropped; the write wins.
  assign rd_vld_d = grant_any & sel_rd & ~sel_wr;
  assign rd_own_d = grant1;
  assign rd_oor_d = ~in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_vld_q <= 1'b0;
    else       rd_vld_q <= rd_vld_d;
  end

  // Tag payload only matters when rd_vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    rd_own_q <= rd_own_d;
    rd_oor_q <= rd_oor_d;
  end

  // Read-return stage: RAM data lands one cycle after the grant.
  assign rd_data          = rd_oor_q ? '0 : ram_readdata;
  assign m0.readdatavalid = rd_vld_q & ~rd_own_q;
  assign m1.readdatavalid = rd_vld_q &  rd_own_q;
  assign m0.readdata      = m0.readdatavalid ? rd_data : '0;
  assign m1.readdata      = m1.readdatavalid ? rd_data : '0;

  a_m0_no_rw: assert property (@(posedge clk) disable iff (reset) !(m0.read && m0.write));
  a_m1_no_rw: assert property (@(posedge clk) disable iff (reset) !(m1.read && m1.write));

endmodule

// File: tb/tb_wiphase_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wiphase_ram_arbiter
// Directed bench for the two-master RAM arbiter with a behavioural 5120x32
// single-port RAM (one-cycle read latency) attached to the ram_* pins.
// -----------------------------------------------------------------------------
module tb_wiphase_ram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic clk = 1'b0;
  logic reset;

  wiphase_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_if ();
  wiphase_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_if ();

  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata;
  logic              err_oor;

  wiphase_ram_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BE_W      (BE_W),
    .DEPTH     (5120),
    .MAX_BURST (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .err_oor        (err_oor)
  );

  always #5 clk = ~clk;

  // Behavioural RAM
  logic [DATA_W-1:0] mem [0:5119];
  always_ff @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
      ram_readdata <= mem[ram_address];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
    m0_if.writedata = d; m0_if.byteenable = be;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
    m1_if.writedata = d; m1_if.byteenable = be;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    // ---- Reset with both masters requesting ----
    reset = 1'b1;
    drv0(1'b0, 1'b1, 13'd100, 32'h0000_0100, 4'hF);
    drv1(1'b0, 1'b1, 13'd101, 32'h0000_0101, 4'hF);
    mid();
    chk("rst_wait0", m0_if.waitrequest, 1'b1);
    chk("rst_wait1", m1_if.waitrequest, 1'b1);
    chk("rst_rdv0", m0_if.readdatavalid, 1'b0);
    chk("rst_rdv1", m1_if.readdatavalid, 1'b0);
    chk("rst_cs", ram_chipselect, 1'b0);
    chk("rst_we", ram_write, 1'b0);
    chk("rst_err", err_oor, 1'b0);
    chk("rst_clken", ram_clken, 1'b1);
    step();
    reset = 1'b0;
    mid();
    chk("tie1_wait0", m0_if.waitrequest, 1'b0);
    chk("tie1_wait1", m1_if.waitrequest, 1'b1);
    step(); idle();
    step();
    drv0(1'b0, 1'b1, 13'd100, 32'h0000_0100, 4'hF);
    drv1(1'b0, 1'b1, 13'd101, 32'h0000_0101, 4'hF);
    mid();
    chk("tie2_wait0", m0_if.waitrequest, 1'b1);
    chk("tie2_wait1", m1_if.waitrequest, 1'b0);
    chk("tie2_addr", ram_address, 13'd101);
    step(); idle();

    // ---- M0 writes 16 words, M1 reads one back ----
    for (int i = 0; i < 16; i++) begin
      step();
      drv0(1'b0, 1'b1, 13'(i), 32'hA5A5_0000 + 32'(i), 4'hF);
      mid();
      chk($sformatf("wr16_wait0_%0d", i), m0_if.waitrequest, 1'b0);
      chk($sformatf("wr16_addr_%0d", i), ram_address, 13'(i));
    end
    step(); idle();
    step();
    drv1(1'b1, 1'b0, 13'd3, '0, 4'hF);
    mid();
    chk("rd3_wait1", m1_if.waitrequest, 1'b0);
    chk("rd3_cs", ram_chipselect, 1'b1);
    chk("rd3_we", ram_write, 1'b0);
    step(); idle();
    mid();
    chk("rd3_rdv1", m1_if.readdatavalid, 1'b1);
    chk("rd3_data", m1_if.readdata, 32'hA5A5_0003);
    chk("rd3_rdv0", m0_if.readdatavalid, 1'b0);

    // ---- Interleaved reads across masters ----
    step();
    drv0(1'b1, 1'b0, 13'd10, '0, 4'hF);
    mid();
    chk("il_wait0", m0_if.waitrequest, 1'b0);
    step();
    drv0(1'b0, 1'b0, '0, '0, '0);
    drv1(1'b1, 1'b0, 13'd11, '0, 4'hF);
    mid();
    chk("il_rdv0", m0_if.readdatavalid, 1'b1);
    chk("il_data0", m0_if.readdata, 32'hA5A5_000A);
    chk("il_rdv1_a", m1_if.readdatavalid, 1'b0);
    chk("il_wait1", m1_if.waitrequest, 1'b0);
    step(); idle();
    mid();
    chk("il_rdv1", m1_if.readdatavalid, 1'b1);
    chk("il_data1", m1_if.readdata, 32'hA5A5_000B);
    chk("il_rdv0_b", m0_if.readdatavalid, 1'b0);

    // ---- Write then read same address next cycle ----
    step(); drv0(1'b0, 1'b1, 13'd20, 32'h1234_5678, 4'hF);
    step(); drv0(1'b1, 1'b0, 13'd20, '0, 4'hF);
    step(); idle();
    mid();
    chk("wr_rd_rdv0", m0_if.readdatavalid, 1'b1);
    chk("wr_rd_data", m0_if.readdata, 32'h1234_5678);

    // ---- Partial byte write from M1 ----
    step(); drv1(1'b0, 1'b1, 13'd7, 32'h1122_3344, 4'b0011);
    step(); drv1(1'b1, 1'b0, 13'd7, '0, 4'hF);
    step(); idle();
    mid();
    chk("be_rdv1", m1_if.readdatavalid, 1'b1);
    chk("be_data", m1_if.readdata, 32'hA5A5_3344);

    // ---- Out-of-range write and read from M1 ----
    step();
    drv1(1'b0, 1'b1, 13'd5120, 32'hDEAD_BEEF, 4'hF);
    mid();
    chk("oorw_wait1", m1_if.waitrequest, 1'b0);
    chk("oorw_cs", ram_chipselect, 1'b0);
    chk("oorw_we", ram_write, 1'b0);
    chk("oorw_err", err_oor, 1'b1);
    step();
    drv1(1'b1, 1'b0, 13'd6000, '0, 4'hF);
    mid();
    chk("oorr_wait1", m1_if.waitrequest, 1'b0);
    chk("oorr_cs", ram_chipselect, 1'b0);
    chk("oorr_err", err_oor, 1'b1);
    step(); idle();
    mid();
    chk("oorr_rdv1", m1_if.readdatavalid, 1'b1);
    chk("oorr_data", m1_if.readdata, 32'h0);
    chk("oorr_err_off", err_oor, 1'b0);

    // ---- Both stream: 8 x M0, 8 x M1, repeating ----
    step();
    drv0(1'b1, 1'b0, 13'd0, '0, 4'hF);
    drv1(1'b1, 1'b0, 13'd1, '0, 4'hF);
    for (int i = 0; i < 32; i++) begin
      mid();
      chk($sformatf("rr_wait0_%0d", i), m0_if.waitrequest, ((i / 8) % 2 == 1));
      chk($sformatf("rr_wait1_%0d", i), m1_if.waitrequest, ((i / 8) % 2 == 0));
      step();
    end
    idle();

    // ---- Reset the cycle after a granted read ----
    step();
    drv0(1'b1, 1'b0, 13'd5, '0, 4'hF);
    mid();
    chk("rrst_wait0", m0_if.waitrequest, 1'b0);
    step();
    reset = 1'b1;
    drv0(1'b0, 1'b1, 13'd200, 32'h0000_0200, 4'hF);
    drv1(1'b0, 1'b1, 13'd201, 32'h0000_0201, 4'hF);
    mid();
    chk("rrst_rdv0", m0_if.readdatavalid, 1'b0);
    chk("rrst_rdv1", m1_if.readdatavalid, 1'b0);
    chk("rrst_wait0_h", m0_if.waitrequest, 1'b1);
    chk("rrst_wait1_h", m1_if.waitrequest, 1'b1);
    chk("rrst_cs", ram_chipselect, 1'b0);
    chk("rrst_we", ram_write, 1'b0);
    chk("rrst_err", err_oor, 1'b0);
    step();
    mid();
    step();
    reset = 1'b0;
    mid();
    chk("post_wait0", m0_if.waitrequest, 1'b0);
    chk("post_wait1", m1_if.waitrequest, 1'b1);
    chk("post_rdv0", m0_if.readdatavalid, 1'b0);
    step(); idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
